// File: rtl/ep_stream_pkg.sv
// Shared types and constants for the endpoint stream reader.
// FSM state encoding, address-select bits and datapath widths.
package ep_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_GAP   = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   // Address MSB: buffer memory vs. register file
   localparam logic BUF_SEL = 1'b0;
   localparam logic REG_SEL = 1'b1;

   localparam int SMP_W  = 16;
   localparam int LEN_W  = 11;
   localparam int WORD_W = 32;

endpackage

// File: rtl/ep_word_fifo.sv
// Synchronous word FIFO with flush; read data is first-word-fall-through.
// Ports: clk_i, rst_i, flush_i, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o.
module ep_word_fifo
   import ep_stream_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WORD_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [WORD_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_q;
   logic [PW-1:0]     rd_q;
   logic [PW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + PW'(1);
         end
         // Simultaneous push and pop leave the count unchanged
         cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ep_stream_reader.sv
// Wishbone read master draining an endpoint buffer into a 16-bit sample stream.
// Ports: start_i/buf_ptr_i/len_i command, busy_o/done_o/err_o status, wb_* master, smp_* stream.
module ep_stream_reader
   import ep_stream_pkg::*;
#(
   parameter int AW         = 13,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [AW-2:0]     buf_ptr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [AW-1:0]     wb_addr_o,
   input  logic [WORD_W-1:0] wb_data_i,
   input  logic              wb_ack_i,
   output logic              wb_we_o,
   output logic              wb_stb_o,
   output logic              wb_cyc_o,
   output logic [SMP_W-1:0]  smp_data_o,
   output logic              smp_valid_o,
   input  logic              smp_ready_i
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   rd_state_e         state_q;
   logic [AW-2:0]     addr_q;
   logic [LEN_W-1:0]  rem_q;
   logic [TW-1:0]     tmo_q;
   logic              stb_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic [WORD_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_cnt;

   logic [SMP_W-1:0]  smp_q;
   logic [SMP_W-1:0]  hi_q;
   logic              smp_vld_q;
   logic              hi_vld_q;

   logic              push;
   logic              pop;
   logic              tmo_hit;
   logic              take;
   logic              drained;

   assign push    = stb_q & wb_ack_i;
   assign tmo_hit = stb_q & ~wb_ack_i & (tmo_q == TMO_LAST);

   // Output register can take a new half this cycle
   assign take    = ~smp_vld_q | smp_ready_i;
   assign pop     = take & ~hi_vld_q & ~fifo_empty & ~tmo_hit;

   // Unpacker and FIFO will both be empty after this edge
   assign drained = fifo_empty & ~hi_vld_q & take;

   assign wb_addr_o   = {BUF_SEL, addr_q};
   assign wb_we_o     = 1'b0;
   assign wb_stb_o    = stb_q;
   assign wb_cyc_o    = stb_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign smp_data_o  = smp_q;
   assign smp_valid_o = smp_vld_q;

   ep_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (tmo_hit),
      .push_i  (push),
      .wdata_i (wb_data_i),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         tmo_q   <= '0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  addr_q <= buf_ptr_i;
                  rem_q  <= len_i;
                  busy_q <= 1'b1;
                  if (len_i == '0) begin
                     state_q <= ST_DRAIN;
                  end else if (fifo_cnt < FULL_CNT) begin
                     state_q <= ST_RD;
                     stb_q   <= 1'b1;
                     tmo_q   <= '0;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_RD: begin
               if (wb_ack_i) begin
                  addr_q  <= addr_q + (AW-1)'(1);
                  rem_q   <= rem_q - LEN_W'(1);
                  stb_q   <= 1'b0;
                  state_q <= ST_GAP;
               end else if (tmo_hit) begin
                  stb_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_GAP: begin
               if (rem_q == '0) begin
                  state_q <= ST_DRAIN;
               end else if (!fifo_full) begin
                  state_q <= ST_RD;
                  stb_q   <= 1'b1;
                  tmo_q   <= '0;
               end
            end
            ST_DRAIN: begin
               if (drained) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               stb_q   <= 1'b0;
            end
         endcase
      end
   end

   // Unpacker: low half first, high half parked until the low half is taken
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         smp_q     <= '0;
         hi_q      <= '0;
         smp_vld_q <= 1'b0;
         hi_vld_q  <= 1'b0;
      end else if (tmo_hit) begin
         smp_vld_q <= 1'b0;
         hi_vld_q  <= 1'b0;
      end else if (take) begin
         if (hi_vld_q) begin
            smp_q     <= hi_q;
            smp_vld_q <= 1'b1;
            hi_vld_q  <= 1'b0;
         end else if (!fifo_empty) begin
            smp_q     <= fifo_rdata[SMP_W-1:0];
            hi_q      <= fifo_rdata[WORD_W-1:SMP_W];
            smp_vld_q <= 1'b1;
            hi_vld_q  <= 1'b1;
         end else begin
            smp_vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ep_stream_reader.sv
// Self-checking bench for ep_stream_reader with a Wishbone slave model.
// Expected streams come from a buffer-memory model indexed by pointer and length.
module tb_ep_stream_reader;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [11:0] buf_ptr_i = '0;
   logic [10:0] len_i = '0;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [12:0] wb_addr_o;
   logic [31:0] wb_data_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [15:0] smp_data_o;
   logic        smp_valid_o;
   logic        smp_ready_i = 1'b1;

   ep_stream_reader #(
      .AW         (13),
      .FIFO_DEPTH (8),
      .TIMEOUT    (255)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .buf_ptr_i   (buf_ptr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .wb_addr_o   (wb_addr_o),
      .wb_data_i   (wb_data_i),
      .wb_ack_i    (wb_ack_i),
      .wb_we_o     (wb_we_o),
      .wb_stb_o    (wb_stb_o),
      .wb_cyc_o    (wb_cyc_o),
      .smp_data_o  (smp_data_o),
      .smp_valid_o (smp_valid_o),
      .smp_ready_i (smp_ready_i)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [4096];

   int ack_lat = 1;
   bit ack_en = 1'b1;
   bit rdy_rand = 1'b0;
   bit rdy_fixed = 1'b1;
   int wcnt = 0;

   // Slave and downstream drivers, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      smp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
      if (rst_i || wb_ack_i) begin
         wb_ack_i = 1'b0;
         wcnt = 0;
      end else if (wb_stb_o) begin
         wcnt++;
         if (ack_en && wcnt > ack_lat) begin
            wb_ack_i = 1'b1;
            wb_data_i = mem[wb_addr_o[11:0]];
         end
      end else begin
         wcnt = 0;
      end
   end

   int cyc = 0;
   int busy_n, stb_n, first_stb, done_n, err_n, done_cyc, last_hs, proto_n;
   bit done_busy;
   logic [12:0] aq [$];
   int ack_cyc [$];
   logic [15:0] sq [$];
   logic [15:0] exp_s [$];
   logic [12:0] exp_a [$];

   // Observer on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (busy_o) busy_n++;
      if (wb_stb_o) begin
         stb_n++;
         if (first_stb < 0) first_stb = cyc;
      end
      if (wb_cyc_o !== wb_stb_o || wb_we_o !== 1'b0) proto_n++;
      if (wb_stb_o && wb_ack_i) begin
         aq.push_back(wb_addr_o);
         ack_cyc.push_back(cyc);
      end
      if (smp_valid_o && smp_ready_i) begin
         sq.push_back(smp_data_o);
         last_hs = cyc;
      end
      if (done_o) begin
         done_n++;
         done_cyc = cyc;
         done_busy = busy_o;
      end
      if (err_o) err_n++;
   end

   function automatic void clear_mon();
      busy_n = 0; stb_n = 0; first_stb = -1; done_n = 0; err_n = 0;
      done_cyc = -1; last_hs = -1; proto_n = 0; done_busy = 1'b1;
      aq.delete(); ack_cyc.delete(); sq.delete();
   endfunction

   // Reference: words at consecutive buffer addresses (mod 4096), low half first
   function automatic void model(int ptr, int len);
      exp_s.delete();
      exp_a.delete();
      for (int i = 0; i < len; i++) begin
         int a;
         logic [31:0] w;
         a = (ptr + i) % 4096;
         w = mem[a];
         exp_a.push_back(13'(a));
         exp_s.push_back(w[15:0]);
         exp_s.push_back(w[31:16]);
      end
   endfunction

   function automatic int first_diff_s();
      int n;
      n = (sq.size() < exp_s.size()) ? sq.size() : exp_s.size();
      for (int i = 0; i < n; i++) if (sq[i] !== exp_s[i]) return i;
      if (sq.size() != exp_s.size()) return n;
      return -1;
   endfunction

   function automatic int first_diff_a();
      int n;
      n = (aq.size() < exp_a.size()) ? aq.size() : exp_a.size();
      for (int i = 0; i < n; i++) if (aq[i] !== exp_a[i]) return i;
      if (aq.size() != exp_a.size()) return n;
      return -1;
   endfunction

   task automatic pulse_start(input int ptr, input int len, output int t0);
      clear_mon();
      @(posedge clk); #1;
      start_i = 1'b1;
      buf_ptr_i = 12'(ptr);
      len_i = 11'(len);
      @(posedge clk); #1;
      start_i = 1'b0;
      t0 = cyc + 1;
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_n + err_n > 0) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({wb_stb_o, wb_cyc_o, wb_we_o} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_bus: stb/cyc/we=%b want 000", {wb_stb_o, wb_cyc_o, wb_we_o});
      end
      vectors++;
      if (wb_addr_o !== 13'h0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h want 0000", wb_addr_o);
      end
      vectors++;
      if ({busy_o, done_o, err_o} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_status: busy/done/err=%b want 000", {busy_o, done_o, err_o});
      end
      vectors++;
      if ({smp_valid_o, smp_data_o} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_smp: valid=%b data=%h want 0/0000", smp_valid_o, smp_data_o);
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      int t0;
      bit ok;
      ack_en = 1'b1; ack_lat = 1; rdy_rand = 1'b0; rdy_fixed = 1'b1;
      mem[16] = 32'h22221111;
      mem[17] = 32'h44443333;
      model(16, 2);
      pulse_start(16, 2, t0);
      wait_end(200, ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_end: finished=%b want 1", ok);
      end
      vectors++;
      if (first_stb !== t0) begin
         miscompares++;
         $display("FAIL basic_stb_latency: stb at cycle %0d want %0d", first_stb, t0);
      end
      vectors++;
      if (first_diff_a() !== -1 || aq[0] !== 13'h0010) begin
         miscompares++;
         $display("FAIL basic_addr: %0d addrs, first %h want 2 from 0010", aq.size(), aq[0]);
      end
      vectors++;
      if (first_diff_s() !== -1 || sq[0] !== 16'h1111 || sq[3] !== 16'h4444) begin
         miscompares++;
         $display("FAIL basic_samples: %0d samples, bad index %0d want 4", sq.size(), first_diff_s());
      end
      vectors++;
      if (ack_cyc.size() != 2 || ack_cyc[1] - ack_cyc[0] != 3) begin
         miscompares++;
         $display("FAIL basic_period: %0d acks, spacing %0d want 3", ack_cyc.size(), ack_cyc[1] - ack_cyc[0]);
      end
      vectors++;
      if (done_n != 1 || err_n != 0 || done_cyc != last_hs + 1 || done_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done: done=%0d err=%0d done_cyc=%0d last_hs=%0d busy=%b want 1/0/last+1/0",
                  done_n, err_n, done_cyc, last_hs, done_busy);
      end
   endtask

   task automatic test_len0();
      int t0;
      bit ok;
      pulse_start($urandom_range(0, 4095), 0, t0);
      wait_end(50, ok);
      vectors++;
      if (ok !== 1'b1 || stb_n != 0) begin
         miscompares++;
         $display("FAIL len0_bus: finished=%b stb_cycles=%0d want 1/0", ok, stb_n);
      end
      vectors++;
      if (done_n != 1 || done_cyc != t0 + 1 || busy_n != 1) begin
         miscompares++;
         $display("FAIL len0_done: done=%0d at %0d busy_cycles=%0d want 1 at %0d, 1",
                  done_n, done_cyc, busy_n, t0 + 1);
      end
   endtask

   task automatic test_backpressure();
      int t0;
      int ptr;
      bit ok;
      ack_lat = 1; rdy_rand = 1'b0; rdy_fixed = 1'b0;
      ptr = $urandom_range(0, 4095);
      model(ptr, 12);
      pulse_start(ptr, 12, t0);
      repeat (100) @(posedge clk);
      @(negedge clk); #1;
      vectors++;
      if (aq.size() != 9 || wb_stb_o !== 1'b0 || sq.size() != 0) begin
         miscompares++;
         $display("FAIL bp_stall: acks=%0d stb=%b samples=%0d want 9/0/0", aq.size(), wb_stb_o, sq.size());
      end
      rdy_rand = 1'b1;
      wait_end(2000, ok);
      vectors++;
      if (ok !== 1'b1 || first_diff_s() !== -1) begin
         miscompares++;
         $display("FAIL bp_samples: finished=%b %0d samples bad index %0d want 24", ok, sq.size(), first_diff_s());
      end
      vectors++;
      if (first_diff_a() !== -1 || done_n != 1) begin
         miscompares++;
         $display("FAIL bp_addr: %0d addrs bad index %0d done=%0d want 12/-1/1", aq.size(), first_diff_a(), done_n);
      end
      rdy_rand = 1'b0; rdy_fixed = 1'b1;
   endtask

   task automatic test_timeout();
      int t0;
      int ptr;
      bit ok;
      ack_en = 1'b0;
      pulse_start($urandom_range(0, 4095), 3, t0);
      wait_end(400, ok);
      vectors++;
      if (ok !== 1'b1 || stb_n != 255) begin
         miscompares++;
         $display("FAIL tmo_stb: finished=%b stb_cycles=%0d want 1/255", ok, stb_n);
      end
      vectors++;
      if (err_n != 1 || done_n != 0 || busy_o !== 1'b0 || wb_stb_o !== 1'b0 || smp_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_status: err=%0d done=%0d busy=%b stb=%b valid=%b want 1/0/0/0/0",
                  err_n, done_n, busy_o, wb_stb_o, smp_valid_o);
      end
      ack_en = 1'b1;
      ptr = $urandom_range(0, 4095);
      model(ptr, 3);
      pulse_start(ptr, 3, t0);
      wait_end(200, ok);
      vectors++;
      if (ok !== 1'b1 || done_n != 1 || first_diff_s() !== -1 || first_diff_a() !== -1) begin
         miscompares++;
         $display("FAIL tmo_recover: finished=%b done=%0d smp_bad=%0d addr_bad=%0d want 1/1/-1/-1",
                  ok, done_n, first_diff_s(), first_diff_a());
      end
   endtask

   task automatic test_wrap();
      int t0;
      bit ok;
      model(12'hFFF, 2);
      pulse_start(12'hFFF, 2, t0);
      wait_end(200, ok);
      vectors++;
      if (ok !== 1'b1 || aq.size() != 2 || aq[0] !== 13'h0FFF || aq[1] !== 13'h0000) begin
         miscompares++;
         $display("FAIL wrap_addr: %0d addrs %h %h want 0fff 0000", aq.size(), aq[0], aq[1]);
      end
      vectors++;
      if (first_diff_s() !== -1) begin
         miscompares++;
         $display("FAIL wrap_samples: %0d samples bad index %0d want 4", sq.size(), first_diff_s());
      end
   endtask

   task automatic test_start_ignored();
      int t0;
      int ptr;
      bit ok;
      ack_lat = 2;
      ptr = $urandom_range(0, 4095);
      model(ptr, 4);
      pulse_start(ptr, 4, t0);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL ign_busy: busy=%b want 1", busy_o);
      end
      start_i = 1'b1;
      buf_ptr_i = 12'(ptr ^ 12'h555);
      len_i = 11'd7;
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_end(300, ok);
      vectors++;
      if (ok !== 1'b1 || first_diff_a() !== -1 || first_diff_s() !== -1 || done_n != 1) begin
         miscompares++;
         $display("FAIL ign_effect: finished=%b %0d addrs addr_bad=%0d smp_bad=%0d done=%0d want 4 addrs",
                  ok, aq.size(), first_diff_a(), first_diff_s(), done_n);
      end
      ack_lat = 1;
   endtask

   task automatic test_reset_mid();
      int t0;
      int ptr;
      bit ok;
      bit found;
      ack_lat = 1; rdy_rand = 1'b0; rdy_fixed = 1'b0;
      pulse_start($urandom_range(0, 4095), 12, t0);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wb_stb_o && smp_valid_o) begin
            found = 1'b1;
            break;
         end
      end
      rst_i = 1'b1;
      #1;
      vectors++;
      if (found !== 1'b1 || {wb_stb_o, wb_cyc_o, busy_o, smp_valid_o} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rst_mid: reached=%b stb/cyc/busy/valid=%b want 1/0000",
                  found, {wb_stb_o, wb_cyc_o, busy_o, smp_valid_o});
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      rdy_fixed = 1'b1;
      ptr = $urandom_range(0, 4095);
      model(ptr, 5);
      pulse_start(ptr, 5, t0);
      wait_end(300, ok);
      vectors++;
      if (ok !== 1'b1 || first_diff_s() !== -1 || first_diff_a() !== -1 || done_n != 1) begin
         miscompares++;
         $display("FAIL rst_after: finished=%b %0d samples smp_bad=%0d addr_bad=%0d done=%0d want 10 clean",
                  ok, sq.size(), first_diff_s(), first_diff_a(), done_n);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      int ptr;
      int len;
      bit ok;
      for (int k = 0; k < 6; k++) begin
         ack_lat = $urandom_range(0, 3);
         rdy_rand = 1'b1;
         ptr = $urandom_range(0, 4095);
         len = $urandom_range(1, 20);
         model(ptr, len);
         pulse_start(ptr, len, t0);
         wait_end(3000, ok);
         vectors++;
         if (ok !== 1'b1 || first_diff_a() !== -1 || first_diff_s() !== -1) begin
            miscompares++;
            $display("FAIL b2b_%0d_data: finished=%b len=%0d addr_bad=%0d smp_bad=%0d",
                     k, ok, len, first_diff_a(), first_diff_s());
         end
         vectors++;
         if (done_n != 1 || err_n != 0 || done_cyc != last_hs + 1 || proto_n != 0) begin
            miscompares++;
            $display("FAIL b2b_%0d_ctrl: done=%0d err=%0d done_cyc=%0d last_hs=%0d proto=%0d",
                     k, done_n, err_n, done_cyc, last_hs, proto_n);
         end
      end
      rdy_rand = 1'b0;
      ack_lat = 1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      clear_mon();
      test_reset();
      test_basic();
      test_len0();
      test_backpressure();
      test_timeout();
      test_wrap();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
